// File: rtl/clk_seq_pkg.sv
// Shared types for the Ace system clock sequencer: FSM states and CPU enable rate codes.
package clk_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN_HOLD  = 2'd2,
    RUN       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DIV1 = 2'd0,
    DIV2 = 2'd1,
    DIV4 = 2'd2,
    DIV8 = 2'd3
  } div_sel_e;

  localparam div_sel_e DIV_SEL_RESET = DIV8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level input; resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clk_seq_ctrl.sv
// Ace system clock sequencer: waits for stable PLL lock, then runs /2 /4 /8 and CPU clock
// enables off a single clock and releases the core reset after a fixed hold.
module clk_seq_ctrl
  import clk_seq_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned RST_HOLD    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic [1:0] div_sel,
  output logic       sys_rst_n,
  output logic       ce_div2,
  output logic       ce_div4,
  output logic       ce_div8,
  output logic       ce_cpu,
  output logic       running
);

  localparam int unsigned LockW = $clog2(LOCK_CYCLES);
  localparam int unsigned HoldW = $clog2(RST_HOLD + 1);
  localparam logic [LockW-1:0] LockLast = LockW'(LOCK_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RST_HOLD - 1);

  logic             w_lock_s;
  state_e           r_state, w_state_nxt;
  logic [LockW-1:0] r_lock_cnt, w_lock_cnt_nxt;
  logic [HoldW-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  div_sel_e         r_active_sel, w_active_sel_nxt;
  logic             r_sys_rst_n;
  logic             w_active;
  logic             w_ce2, w_ce4, w_ce8, w_ce_cpu;

  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  assign w_active = (r_state == RUN_HOLD) || (r_state == RUN);

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    w_cnt_nxt      = r_cnt;
    unique case (r_state)
      WAIT_LOCK: begin
        w_lock_cnt_nxt = '0;
        if (w_lock_s) w_state_nxt = STABLE;
      end
      STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt    = WAIT_LOCK;
          w_lock_cnt_nxt = '0;
        end else if (r_lock_cnt == LockLast) begin
          w_state_nxt    = RUN_HOLD;
          w_cnt_nxt      = '0;
          w_hold_cnt_nxt = '0;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + LockW'(1);
        end
      end
      RUN_HOLD: begin
        // Lock loss takes priority over the hold terminal count.
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt      = r_cnt + 3'd1;
          w_hold_cnt_nxt = r_hold_cnt + HoldW'(1);
          if (r_hold_cnt == HoldLast) w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  // Rate changes only land on the frame boundary so no CPU period is ever cut or stretched.
  always_comb begin
    w_active_sel_nxt = r_active_sel;
    if (!w_active || (r_cnt == 3'd7)) w_active_sel_nxt = div_sel_e'(div_sel);
  end

  always_comb begin
    w_ce2    = w_active & r_cnt[0];
    w_ce4    = w_active & (r_cnt[1:0] == 2'b11);
    w_ce8    = w_active & (r_cnt == 3'd7);
    w_ce_cpu = 1'b0;
    unique case (r_active_sel)
      DIV1:    w_ce_cpu = w_active;
      DIV2:    w_ce_cpu = w_ce2;
      DIV4:    w_ce_cpu = w_ce4;
      DIV8:    w_ce_cpu = w_ce8;
      default: w_ce_cpu = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_LOCK;
      r_lock_cnt   <= '0;
      r_hold_cnt   <= '0;
      r_cnt        <= '0;
      r_active_sel <= DIV_SEL_RESET;
      r_sys_rst_n  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_cnt        <= w_cnt_nxt;
      r_active_sel <= w_active_sel_nxt;
      r_sys_rst_n  <= (w_state_nxt == RUN);
    end
  end

  assign sys_rst_n = r_sys_rst_n;
  assign running   = (r_state == RUN);
  assign ce_div2   = w_ce2;
  assign ce_div4   = w_ce4;
  assign ce_div8   = w_ce8;
  assign ce_cpu    = w_ce_cpu;

endmodule

// File: tb/tb_clk_seq_ctrl.sv
// Bench for clk_seq_ctrl: lock-streak reference model checked every cycle, plus directed
// timing/ratio/rate-change checks with hand-computed expectations.
module tb_clk_seq_ctrl;

  localparam int L = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic [1:0] div_sel;
  logic       sys_rst_n, ce_div2, ce_div4, ce_div8, ce_cpu, running;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the machine is fully described by how many consecutive synchronised-lock samples
  // have been seen; enables run once that streak exceeds L, the frame phase is the excess.
  logic m_s1 = 1'b0, m_s2 = 1'b0;
  int   m_streak = 0;
  int   m_sel = 3;

  clk_seq_ctrl #(
    .LOCK_CYCLES (L),
    .RST_HOLD    (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_lock  (pll_lock),
    .div_sel   (div_sel),
    .sys_rst_n (sys_rst_n),
    .ce_div2   (ce_div2),
    .ce_div4   (ce_div4),
    .ce_div8   (ce_div8),
    .ce_cpu    (ce_cpu),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model update.
  initial begin
    logic ls;
    bit   pre_act;
    int   pre_cnt;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = 1'b0; m_s2 = 1'b0; m_streak = 0; m_sel = 3;
      end else begin
        pre_act = (m_streak >= L + 1);
        pre_cnt = pre_act ? (m_streak - (L + 1)) % 8 : 0;
        if (!pre_act || pre_cnt == 7) m_sel = int'(div_sel);
        ls = m_s2; m_s2 = m_s1; m_s1 = pll_lock;
        if (ls) m_streak++;
        else m_streak = 0;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    bit act, e2, e4, e8, erun, ecpu;
    int age;
    forever begin
      @(negedge clk);
      act  = (m_streak >= L + 1);
      age  = act ? m_streak - (L + 1) : 0;
      e2   = act && (age % 2 == 1);
      e4   = act && (age % 4 == 3);
      e8   = act && (age % 8 == 7);
      erun = act && (age >= H);
      case (m_sel)
        0:       ecpu = act;
        1:       ecpu = e2;
        2:       ecpu = e4;
        default: ecpu = e8;
      endcase
      check("model_ce_div2", ce_div2, e2);
      check("model_ce_div4", ce_div4, e4);
      check("model_ce_div8", ce_div8, e8);
      check("model_ce_cpu", ce_cpu, ecpu);
      check("model_running", running, erun);
      check("model_sys_rst_n", sys_rst_n, erun);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Call at a negedge: raise lock and time first ce_div2 and reset release in clk edges.
  task automatic lock_and_wait(output int t_ce2, output int t_rst);
    t_ce2 = -1; t_rst = -1;
    pll_lock = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (t_ce2 < 0 && ce_div2) t_ce2 = k;
      if (sys_rst_n) begin
        t_rst = k;
        break;
      end
    end
  endtask

  task automatic drop_lock(output int t);
    t = -1;
    pll_lock = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (!sys_rst_n) begin
        t = k;
        break;
      end
    end
  endtask

  initial begin
    int t1, t2, c2, c4, c8, bad, ccpu, found, lock_low;
    rst_n = 1'b0; pll_lock = 1'b0; div_sel = 2'd3;
    #1;
    check("reset_outputs", {26'd0, sys_rst_n, running, ce_div2, ce_div4, ce_div8, ce_cpu}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (sys_rst_n || running || ce_div2 || ce_cpu) bad++;
    end
    check("no_lock_idle", bad, 0);

    // Lock sequence
    @(negedge clk);
    lock_and_wait(t1, t2);
    check("first_ce_div2_edge", t1, 8);
    check("sys_rst_release_edge", t2, 10);
    check("running_with_release", running, 1);

    // Glitch during STABLE
    @(negedge clk);
    drop_lock(t1);
    check("lock_loss_latency_1", t1, 3);
    repeat (5) @(negedge clk);
    pll_lock = 1'b1;
    repeat (2) @(negedge clk);
    pll_lock = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (sys_rst_n || ce_div2 || ce_div8) bad++;
    end
    check("glitch_no_run", bad, 0);
    lock_and_wait(t1, t2);
    check("relock_ce_div2_edge", t1, 8);
    check("relock_release_edge", t2, 10);

    // Enable ratios
    c2 = 0; c4 = 0; c8 = 0; bad = 0;
    @(negedge clk);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      c2 += int'(ce_div2); c4 += int'(ce_div4); c8 += int'(ce_div8);
      if (ce_div8 && !(ce_div4 && ce_div2)) bad++;
    end
    check("ratio_div2", c2, 32);
    check("ratio_div4", c4, 16);
    check("ratio_div8", c8, 8);
    check("div8_coincide", bad, 0);

    // Rate change 3 -> 1 at cnt=2
    found = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (ce_div8) begin found = 1; break; end
    end
    check("frame_found_1", found, 1);
    repeat (3) @(negedge clk);
    div_sel = 2'd1;
    ccpu = 0;
    repeat (13) begin @(negedge clk); ccpu += int'(ce_cpu); end
    check("rate_3_to_1_pulses", ccpu, 5);
    // Now at cnt=7; 1->0 at cnt=0, 0->2 at cnt=3: only /4 applies next frame
    @(negedge clk);
    div_sel = 2'd0;
    repeat (3) @(negedge clk);
    div_sel = 2'd2;
    ccpu = 0;
    repeat (12) begin @(negedge clk); ccpu += int'(ce_cpu); end
    check("rate_last_wins_pulses", ccpu, 4);

    // Lock loss in RUN
    @(negedge clk);
    drop_lock(t1);
    check("lock_loss_latency_2", t1, 3);
    check("running_after_loss", running, 0);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (ce_div2 || ce_div4 || ce_div8 || ce_cpu) bad++;
    end
    check("ce_stop_after_loss", bad, 0);
    div_sel = 2'd0;
    lock_and_wait(t1, t2);
    check("relock2_release_edge", t2, 10);

    // Async reset mid-RUN
    repeat (4) @(negedge clk);
    check("pre_reset_ce_cpu", ce_cpu, 1);
    @(posedge clk); #2;
    rst_n = 1'b0; pll_lock = 1'b0;
    #1;
    check("async_reset_outputs", {26'd0, sys_rst_n, running, ce_div2, ce_div4, ce_div8, ce_cpu}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (sys_rst_n || running || ce_div2 || ce_div4 || ce_div8 || ce_cpu) bad++;
    end
    check("post_reset_idle", bad, 0);

    // Randomized operation against the model
    lock_low = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (lock_low > 0) begin
        pll_lock = 1'b0;
        lock_low--;
      end else if ($urandom_range(0, 149) == 0) begin
        lock_low = $urandom_range(1, 6);
        pll_lock = 1'b0;
      end else begin
        pll_lock = 1'b1;
      end
      if ($urandom_range(0, 5) == 0) div_sel = 2'($urandom_range(0, 3));
      if (k == 1500) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
